// File: rtl/xor_cipher_pkg.sv
// Shared types and helpers for the serial XOR stream cipher.
//   cipher_state_e : controller states
//   expandKey()    : repeats a KEY_SIZE-bit key cyclically, MSB first, out to MSG_SIZE bits
package xor_cipher_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadKey,
    StLoadMsg,
    StEncrypt,
    StShiftOut
  } cipher_state_e;

  // Upper bound on key/message width handled by expandKey().
  localparam int MaxWidth = 64;
  localparam int IdxW     = $clog2(MaxWidth);

  // kx[msgSize-1-i] = key[keySize-1-(i mod keySize)]; sizes are elaboration constants at every
  // call site, so the loop collapses to plain wiring.
  function automatic logic [MaxWidth-1:0] expandKey(input logic [MaxWidth-1:0] key,
                                                    input int keySize,
                                                    input int msgSize);
    logic [MaxWidth-1:0] kx;
    kx = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      if (i < msgSize) begin
        kx[IdxW'(msgSize - 1 - i)] = key[IdxW'(keySize - 1 - (i % keySize))];
      end
    end
    return kx;
  endfunction

endpackage

// File: rtl/xor_sipo.sv
// Serial-in parallel-out capture with bit counter, used for both key and message.
//   iClk      : clock, rising edge
//   iRst      : synchronous active-high reset
//   iEn       : global enable, low freezes everything
//   iShift    : iData is a bit for this shifter this cycle
//   iData     : serial bit, MSB first
//   oWordNext : full word including the current bit, meaningful while oDone is high
//   oDone     : combinational strobe, the current bit completes the word
// A cycle with iShift low while a word is part-way in discards the partial word.
module xor_sipo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iShift,
  input  logic             iData,
  output logic [WIDTH-1:0] oWordNext,
  output logic             oDone
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shifter;
  logic [CntW-1:0]  bitCnt;
  logic             lastBit;

  // Concatenate then truncate so WIDTH=1 needs no special case.
  assign oWordNext = WIDTH'({shifter, iData});
  assign lastBit   = (bitCnt == CntW'(WIDTH - 1));
  assign oDone     = iEn && iShift && lastBit;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      shifter <= '0;
      bitCnt  <= '0;
    end else if (iEn) begin
      if (iShift) begin
        if (lastBit) begin
          shifter <= '0;
          bitCnt  <= '0;
        end else begin
          shifter <= oWordNext;
          bitCnt  <= bitCnt + CntW'(1);
        end
      end else if (bitCnt != '0) begin
        shifter <= '0;
        bitCnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// Serial XOR cipher: captures a key and a message from one serial input, XORs the message
// with the cyclically repeated key and shifts the ciphertext out MSB first.
//   iClk        : clock, rising edge
//   iRst        : synchronous active-high reset
//   iEn         : global enable, low freezes all state and outputs
//   iData_in    : serial key/message bit, MSB first
//   iLoad_key   : iData_in is a key bit (wins over iLoad_msg)
//   iLoad_msg   : iData_in is a message bit
//   oData_out   : ciphertext bit
//   oValid      : oData_out carries a ciphertext bit
//   oDone_flag  : pulse with the last ciphertext bit
//   oBusy       : encrypt/shift-out in progress, loads ignored
//   oKey_ready  : complete key held
//   oErr        : pulse, message completed with no key
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int unsigned KEY_SIZE = 4,
  parameter int unsigned MSG_SIZE = 8,
  parameter int unsigned ROLL_KEY = 0
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iData_in,
  input  logic iLoad_key,
  input  logic iLoad_msg,
  output logic oData_out,
  output logic oValid,
  output logic oDone_flag,
  output logic oBusy,
  output logic oKey_ready,
  output logic oErr
);

  localparam int unsigned OutCntW = $clog2(MSG_SIZE);

  cipher_state_e       state;
  logic [KEY_SIZE-1:0] keyReg;
  logic [KEY_SIZE-1:0] keyWord;
  logic [KEY_SIZE-1:0] keyRot;
  logic [MSG_SIZE-1:0] msgReg;
  logic [MSG_SIZE-1:0] msgWord;
  logic [MSG_SIZE-1:0] ctReg;
  logic [MSG_SIZE-1:0] kx;
  logic [OutCntW-1:0]  outCnt;
  logic                keyShift;
  logic                msgShift;
  logic                keyDone;
  logic                msgDone;

  // Key bits only land in IDLE/LOAD_KEY; message bits only in IDLE/LOAD_MSG and only when the
  // key strobe is low.
  assign keyShift = iLoad_key && (state == StIdle || state == StLoadKey);
  assign msgShift = iLoad_msg && !iLoad_key && (state == StIdle || state == StLoadMsg);

  assign kx     = MSG_SIZE'(expandKey(MaxWidth'(keyReg), int'(KEY_SIZE), int'(MSG_SIZE)));
  assign keyRot = KEY_SIZE'({keyReg, keyReg} >> (KEY_SIZE - 1));

  xor_sipo #(
    .WIDTH(KEY_SIZE)
  ) u_keySipo (
    .iClk     (iClk),
    .iRst     (iRst),
    .iEn      (iEn),
    .iShift   (keyShift),
    .iData    (iData_in),
    .oWordNext(keyWord),
    .oDone    (keyDone)
  );

  xor_sipo #(
    .WIDTH(MSG_SIZE)
  ) u_msgSipo (
    .iClk     (iClk),
    .iRst     (iRst),
    .iEn      (iEn),
    .iShift   (msgShift),
    .iData    (iData_in),
    .oWordNext(msgWord),
    .oDone    (msgDone)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= StIdle;
      keyReg     <= '0;
      msgReg     <= '0;
      ctReg      <= '0;
      outCnt     <= '0;
      oData_out  <= 1'b0;
      oValid     <= 1'b0;
      oDone_flag <= 1'b0;
      oBusy      <= 1'b0;
      oKey_ready <= 1'b0;
      oErr       <= 1'b0;
    end else if (iEn) begin
      oDone_flag <= 1'b0;
      oErr       <= 1'b0;

      // Starting a key reload invalidates the held key until the new one is complete.
      if (keyDone) begin
        keyReg     <= keyWord;
        oKey_ready <= 1'b1;
      end else if (keyShift) begin
        oKey_ready <= 1'b0;
      end

      case (state)
        StIdle, StLoadKey, StLoadMsg: begin
          oValid    <= 1'b0;
          oData_out <= 1'b0;
          if (keyShift) begin
            state <= keyDone ? StIdle : StLoadKey;
          end else if (msgShift) begin
            if (!msgDone) begin
              state <= StLoadMsg;
            end else if (oKey_ready) begin
              msgReg <= msgWord;
              oBusy  <= 1'b1;
              state  <= StEncrypt;
            end else begin
              oErr  <= 1'b1;
              state <= StIdle;
            end
          end else begin
            state <= StIdle;
          end
        end
        StEncrypt: begin
          ctReg  <= msgReg ^ kx;
          outCnt <= '0;
          state  <= StShiftOut;
        end
        StShiftOut: begin
          oValid    <= 1'b1;
          oData_out <= ctReg[MSG_SIZE-1];
          ctReg     <= ctReg << 1;
          outCnt    <= outCnt + OutCntW'(1);
          if (outCnt == OutCntW'(MSG_SIZE - 1)) begin
            oDone_flag <= 1'b1;
            oBusy      <= 1'b0;
            state      <= StIdle;
            if (ROLL_KEY != 0) begin
              keyReg <= keyRot;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Bench for xor_stream_cipher: three instances (static 4-bit key, rolling 4-bit key, static
// 3-bit key) share the serial bus; each has its own key strobe. A transaction-level model
// predicts each ciphertext and error pulse; a negedge monitor assembles the output streams.
module tb_xor_stream_cipher;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iEn;
  logic       iData_in;
  logic       iLoad_msg;
  logic [2:0] loadKey;
  logic [2:0] dOut, dValid, dDone, dBusy, dKeyReady, dErr;

  always #5 iClk = ~iClk;

  xor_stream_cipher #(.KEY_SIZE(4), .MSG_SIZE(8), .ROLL_KEY(0)) dutStatic (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iData_in(iData_in), .iLoad_key(loadKey[0]),
    .iLoad_msg(iLoad_msg), .oData_out(dOut[0]), .oValid(dValid[0]), .oDone_flag(dDone[0]),
    .oBusy(dBusy[0]), .oKey_ready(dKeyReady[0]), .oErr(dErr[0])
  );

  xor_stream_cipher #(.KEY_SIZE(4), .MSG_SIZE(8), .ROLL_KEY(1)) dutRoll (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iData_in(iData_in), .iLoad_key(loadKey[1]),
    .iLoad_msg(iLoad_msg), .oData_out(dOut[1]), .oValid(dValid[1]), .oDone_flag(dDone[1]),
    .oBusy(dBusy[1]), .oKey_ready(dKeyReady[1]), .oErr(dErr[1])
  );

  xor_stream_cipher #(.KEY_SIZE(3), .MSG_SIZE(8), .ROLL_KEY(0)) dutKey3 (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iData_in(iData_in), .iLoad_key(loadKey[2]),
    .iLoad_msg(iLoad_msg), .oData_out(dOut[2]), .oValid(dValid[2]), .oDone_flag(dDone[2]),
    .oBusy(dBusy[2]), .oKey_ready(dKeyReady[2]), .oErr(dErr[2])
  );

  int         nVec = 0;
  int         nMiss = 0;
  int         keySz[3] = '{4, 4, 3};
  bit         rollOn[3] = '{1'b0, 1'b1, 1'b0};
  int         mKey[3];
  bit         mReady[3];
  logic [7:0] expQ[3][$];
  int         errExp[3];
  int         errSeen[3];
  logic [7:0] acc[3];
  int         bitCnt[3];
  bit         prevEn = 1'b0;
  bit         prevRst = 1'b0;
  bit         gapsOn = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Key written out repeatedly end to end, then the first 8 bits kept.
  function automatic logic [7:0] expandRef(input int key, input int ks);
    longint rep = 0;
    int     len = 0;
    while (len < 8) begin
      rep = (rep << ks) | longint'(key);
      len += ks;
    end
    return 8'(rep >> (len - 8));
  endfunction

  function automatic int rotl(input int key, input int ks);
    return ((key << 1) | (key >> (ks - 1))) & ((1 << ks) - 1);
  endfunction

  // Outputs seen at a negedge belong to the preceding posedge, whose enable was sampled at the
  // previous negedge.
  always @(negedge iClk) begin
    if (prevRst) begin
      for (int d = 0; d < 3; d++) begin
        acc[d]    = '0;
        bitCnt[d] = 0;
      end
    end else if (prevEn) begin
      for (int d = 0; d < 3; d++) begin
        if (dValid[d]) begin
          checkVal($sformatf("dut%0d valid with ciphertext pending", d), expQ[d].size() > 0, 1);
          acc[d] = {acc[d][6:0], dOut[d]};
          bitCnt[d]++;
        end
        if (dDone[d]) begin
          checkVal($sformatf("dut%0d bits per message", d), bitCnt[d], 8);
          if (expQ[d].size() > 0) begin
            checkVal($sformatf("dut%0d ciphertext", d), acc[d], expQ[d].pop_front());
          end
          bitCnt[d] = 0;
        end
        if (dErr[d]) errSeen[d]++;
      end
    end
    prevRst = iRst;
    prevEn  = iEn;
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic sendBit(input logic d, input logic [2:0] lk, input logic lm);
    iData_in  = d;
    loadKey   = lk;
    iLoad_msg = lm;
    if (gapsOn && $urandom_range(0, 3) == 0) begin
      iEn = 1'b0;
      tick();
      iEn = 1'b1;
    end
    tick();
  endtask

  task automatic loadKeyTo(input logic [2:0] tgt, input int key, input int ks);
    for (int i = 0; i < ks; i++) sendBit(1'((key >> (ks - 1 - i)) & 1), tgt, 1'b0);
    loadKey = '0;
    for (int d = 0; d < 3; d++) begin
      if (tgt[d]) begin
        mKey[d]   = key;
        mReady[d] = 1'b1;
      end
    end
  endtask

  task automatic sendMsg(input logic [7:0] msg);
    for (int i = 0; i < 8; i++) sendBit(msg[7-i], 3'b000, 1'b1);
    iLoad_msg = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (mReady[d]) begin
        expQ[d].push_back(msg ^ expandRef(mKey[d], keySz[d]));
        if (rollOn[d]) mKey[d] = rotl(mKey[d], keySz[d]);
      end else begin
        errExp[d]++;
      end
    end
  endtask

  // Run until every instance has left the busy phase; optionally wiggle the message strobe
  // while all are busy, where it must be ignored.
  task automatic drain(input bit junk);
    int k;
    for (k = 0; k < 100; k++) begin
      if (junk && dBusy == 3'b111) begin
        iLoad_msg = 1'($urandom_range(0, 1));
        iData_in  = 1'($urandom_range(0, 1));
      end else begin
        iLoad_msg = 1'b0;
      end
      iEn = !(gapsOn && $urandom_range(0, 3) == 0);
      tick();
      if (dBusy == 3'b000 && iEn) break;
    end
    iEn       = 1'b1;
    iLoad_msg = 1'b0;
    tick();
    checkVal("drain within cycle budget", k < 100, 1);
  endtask

  task automatic checkModelAligned(input string tag);
    for (int d = 0; d < 3; d++) begin
      checkVal($sformatf("%s dut%0d error pulses", tag, d), errSeen[d], errExp[d]);
      checkVal($sformatf("%s dut%0d pending ciphertexts", tag, d), expQ[d].size(), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] holdOut;
    int         k4;

    iRst = 1'b1; iEn = 1'b1; iData_in = 1'b0; iLoad_msg = 1'b0; loadKey = '0;
    tick(); tick();
    iRst = 1'b0;
    checkVal("reset oData_out", dOut, 0);
    checkVal("reset oValid", dValid, 0);
    checkVal("reset oDone_flag", dDone, 0);
    checkVal("reset oBusy", dBusy, 0);
    checkVal("reset oKey_ready", dKeyReady, 0);
    checkVal("reset oErr", dErr, 0);

    // Message with no key: one error pulse, no stream.
    sendMsg(8'hFF);
    drain(1'b0);
    checkModelAligned("no key");

    // Partial key then drop: nothing held.
    sendBit(1'b1, 3'b011, 1'b0);
    sendBit(1'b0, 3'b011, 1'b0);
    loadKey = '0;
    tick();
    checkVal("partial key oKey_ready", dKeyReady, 0);

    // Directed: key 1010 / 110, message 0x3C, with exact output timing.
    loadKeyTo(3'b011, 4'b1010, 4);
    loadKeyTo(3'b100, 3'b110, 3);
    tick();
    checkVal("keys ready", dKeyReady, 3'b111);
    sendMsg(8'h3C);
    checkVal("busy after last message bit", dBusy, 3'b111);
    checkVal("no valid during encrypt", dValid, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkVal($sformatf("oValid edge N+%0d", k), dValid[0], (k >= 2 && k <= 9));
      checkVal($sformatf("oDone_flag edge N+%0d", k), dDone[0], (k == 9));
      if (k == 2) checkVal("first ciphertext bit", dOut, 3'b111);
    end
    checkModelAligned("first message");

    // Same message again (rolled key differs), with a 3-cycle enable gap mid-stream.
    sendMsg(8'h3C);
    for (int k = 0; k < 4; k++) tick();
    holdOut = dOut;
    iEn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal("gap holds oData_out", dOut, holdOut);
      checkVal("gap holds oValid", dValid, 3'b111);
    end
    iEn = 1'b1;
    drain(1'b1);
    checkModelAligned("rolled message");

    sendMsg(8'h00);
    drain(1'b1);
    checkModelAligned("zero message");

    // Reset after the fourth ciphertext bit.
    sendMsg(8'hA5);
    for (int k = 0; k < 5; k++) tick();
    checkVal("streaming before reset", dValid, 3'b111);
    iRst = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      expQ[d].delete();
      mReady[d] = 1'b0;
    end
    checkVal("reset mid-shift oValid", dValid, 0);
    checkVal("reset mid-shift oKey_ready", dKeyReady, 0);
    checkVal("reset mid-shift oDone_flag", dDone, 0);
    checkVal("reset mid-shift oBusy", dBusy, 0);
    iRst = 1'b0;
    tick();
    checkVal("no done after reset", dDone, 0);

    // Key and message strobes together: only the key advances.
    k4 = int'($urandom_range(0, 15));
    for (int i = 0; i < 3; i++) sendBit(1'((k4 >> (3 - i)) & 1), 3'b111, 1'b1);
    sendBit(1'(k4 & 1), 3'b011, 1'b1);
    loadKey = '0;
    iLoad_msg = 1'b0;
    tick();
    mKey[0] = k4; mKey[1] = k4; mKey[2] = k4 >> 1;
    for (int d = 0; d < 3; d++) mReady[d] = 1'b1;
    checkVal("simultaneous strobes keys ready", dKeyReady, 3'b111);
    sendMsg(8'($urandom));
    drain(1'b1);
    checkModelAligned("simultaneous strobes");

    // Random traffic with enable gaps and occasional key reloads.
    gapsOn = 1'b1;
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 2) == 0) loadKeyTo(3'b011, int'($urandom_range(0, 15)), 4);
      if ($urandom_range(0, 3) == 0) loadKeyTo(3'b100, int'($urandom_range(0, 7)), 3);
      sendMsg(8'($urandom));
      drain(1'b1);
    end
    gapsOn = 1'b0;
    tick();
    checkModelAligned("random traffic");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
